// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and sends each byte as an 8N1 UART frame.
// One byte is in flight at most; the FIFO is only popped from IDLE.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_data_in,
  output logic       o_read_enable,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_COUNT     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST_COUNT = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    STOP
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_baudCount;
  logic [2:0]      r_bitIdx;
  logic [7:0]      r_shift;
  logic            r_readEnable;
  logic            r_tx;
  logic            r_busy;
  logic            r_txDone;

  assign o_read_enable = r_readEnable;
  assign o_tx          = r_tx;
  assign o_busy        = r_busy;
  assign o_tx_done     = r_txDone;

  // Frame sequencer; every output is set for the state being entered so
  // that outputs line up with the state register without any input path.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_baudCount  <= '0;
      r_bitIdx     <= '0;
      r_shift      <= '0;
      r_readEnable <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_txDone     <= 1'b0;
    end else begin
      r_readEnable <= 1'b0;
      r_txDone     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baudCount <= '0;
          if (!i_fifo_empty) begin
            r_state      <= POP;
            r_readEnable <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        POP: begin
          r_state     <= LATCH;
          r_baudCount <= '0;
        end
        LATCH: begin
          r_shift     <= i_data_in;
          r_state     <= START;
          r_tx        <= 1'b0;
          r_baudCount <= '0;
        end
        START: begin
          if (r_baudCount == LAST_COUNT) begin
            r_state     <= DATA;
            r_baudCount <= '0;
            r_bitIdx    <= '0;
            r_tx        <= r_shift[0];
          end else begin
            r_baudCount <= r_baudCount + CW'(1);
          end
        end
        DATA: begin
          if (r_baudCount == LAST_COUNT) begin
            r_baudCount <= '0;
            r_shift     <= {1'b0, r_shift[7:1]};
            if (r_bitIdx == 3'd7) begin
              r_state <= STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
              r_tx     <= r_shift[1];
            end
          end else begin
            r_baudCount <= r_baudCount + CW'(1);
          end
        end
        STOP: begin
          if (r_baudCount == LAST_COUNT) begin
            r_state     <= IDLE;
            r_baudCount <= '0;
            r_busy      <= 1'b0;
          end else begin
            r_baudCount <= r_baudCount + CW'(1);
            if (r_baudCount == PRE_LAST_COUNT) begin
              r_txDone <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_baudCount <= '0;
          r_tx        <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: drives two transmitters (4 and 2 clocks per bit) from a
// queue-based FIFO and compares every cycle against a frame-timing model.
module tb_fifo_uart_tx;

  logic       clk;
  logic       reset;
  logic       emptyA, emptyB;
  logic [7:0] dataA, dataB;
  logic       reA, txA, busyA, doneA;
  logic       reB, txB, busyB, doneB;

  int checks;
  int errors;
  int popCnt, busyCnt, doneCnt;

  logic [7:0] expBytes[$];
  logic [7:0] fifoQ[$];

  fifo_uart_tx #(.CLKS_PER_BIT(4)) dutA (
    .i_clk(clk), .i_reset(reset), .i_fifo_empty(emptyA), .i_data_in(dataA),
    .o_read_enable(reA), .o_tx(txA), .o_busy(busyA), .o_tx_done(doneA)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(2)) dutB (
    .i_clk(clk), .i_reset(reset), .i_fifo_empty(emptyB), .i_data_in(dataB),
    .o_read_enable(reB), .o_tx(txB), .o_busy(busyB), .o_tx_done(doneB)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected {read_enable, tx, busy, tx_done} at cycle o, where o=0 is the
  // first pop cycle; each byte takes 10*cpb frame cycles plus pop, latch, idle
  function automatic logic [3:0] expOut(input int o, input int cpb);
    int period, k, r, t, b;
    logic txb;
    logic [7:0] by;
    period = 10 * cpb + 3;
    if (o < 0) return 4'b0100;
    k = o / period;
    r = o % period;
    if (k >= expBytes.size()) return 4'b0100;
    if (r == 0) return 4'b1110;
    if (r == 1) return 4'b0110;
    if (r < 2 + 10 * cpb) begin
      t = r - 2;
      b = t / cpb;
      by = expBytes[k];
      if (b == 0) txb = 1'b0;
      else if (b == 9) txb = 1'b1;
      else txb = by[b - 1];
      return {1'b0, txb, 1'b1, (t == 10 * cpb - 1)};
    end
    return 4'b0100;
  endfunction

  // Single comparison point with failure accounting
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] sampleOut(input int sel);
    return (sel != 0) ? {reB, txB, busyB, doneB} : {reA, txA, busyA, doneA};
  endfunction

  // Runs nCycles cycles, checking outputs and serving pops from fifoQ
  task automatic applyStimulus(input int sel, input int nCycles, input string tag);
    logic [3:0] obs;
    logic [7:0] d;
    int cpb;
    cpb = (sel != 0) ? 2 : 4;
    for (int o = 0; o < nCycles; o++) begin
      @(negedge clk);
      obs = sampleOut(sel);
      checkOutput(tag, {28'd0, obs}, {28'd0, expOut(o, cpb)});
      if (obs[3]) popCnt++;
      if (obs[1]) busyCnt++;
      if (obs[0]) doneCnt++;
      if (obs[3] && fifoQ.size() > 0) begin
        d = fifoQ.pop_front();
        if (sel != 0) dataB = d; else dataA = d;
      end
      if (sel != 0) emptyB = (fifoQ.size() == 0);
      else emptyA = (fifoQ.size() == 0);
    end
  endtask

  // Loads expBytes into the FIFO after one checked idle cycle, runs all
  // frames plus slack, then checks pop/busy/done totals
  task automatic runScenario(input int sel, input string tag);
    int cpb, n;
    cpb = (sel != 0) ? 2 : 4;
    n = expBytes.size();
    @(negedge clk);
    checkOutput({tag, "_idle"}, {28'd0, sampleOut(sel)}, 32'h4);
    fifoQ = expBytes;
    popCnt = 0; busyCnt = 0; doneCnt = 0;
    if (sel != 0) emptyB = (fifoQ.size() == 0);
    else emptyA = (fifoQ.size() == 0);
    applyStimulus(sel, n * (10 * cpb + 3) + 3, tag);
    checkOutput({tag, "_pops"}, popCnt, n);
    checkOutput({tag, "_busy"}, busyCnt, n * (10 * cpb + 2));
    checkOutput({tag, "_done"}, doneCnt, n);
  endtask

  initial begin
    checks = 0; errors = 0;
    popCnt = 0; busyCnt = 0; doneCnt = 0;
    reset = 1'b1;
    emptyA = 1'b1; emptyB = 1'b1;
    dataA = 8'h00; dataB = 8'h00;
    $display("[TB] start");

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_A", {28'd0, sampleOut(0)}, 32'h4);
    checkOutput("reset_B", {28'd0, sampleOut(1)}, 32'h4);
    reset = 1'b0;

    expBytes = '{8'h33};
    runScenario(0, "single33");

    expBytes = '{8'h33, 8'hCC};
    runScenario(0, "b2b");

    expBytes = '{};
    runScenario(0, "empty");
    applyStimulus(0, 200, "empty200");
    checkOutput("empty_pops", popCnt, 0);

    expBytes = '{8'hFF};
    runScenario(1, "baudFF");

    expBytes = '{8'h00};
    runScenario(0, "zero");

    expBytes = '{8'h00};
    runScenario(1, "zeroB");

    expBytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
    runScenario(0, "randA");

    expBytes = '{8'($urandom), 8'($urandom)};
    runScenario(1, "randB");

    // Reset during data bit 3 of 0xA5, with another byte still queued
    expBytes = '{8'hA5};
    @(negedge clk);
    checkOutput("rst_idle", {28'd0, sampleOut(0)}, 32'h4);
    fifoQ = '{8'hA5, 8'h5A};
    emptyA = 1'b0;
    applyStimulus(0, 20, "rst_pre");
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_next", {28'd0, sampleOut(0)}, 32'h4);
    reset = 1'b0;
    expBytes = '{8'h5A};
    popCnt = 0; busyCnt = 0; doneCnt = 0;
    applyStimulus(0, 43, "rst_post");
    checkOutput("rst_post_pops", popCnt, 1);
    checkOutput("rst_post_done", doneCnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter that drains the byte FIFO: whenever the FIFO reports non-empty, it pops one byte, frames it as 8N1 UART (start bit, 8 data bits LSB-first, stop bit), and shifts it out on a single line at a fixed clocks-per-bit rate. It sits directly downstream of the FIFO. Its read strobe drives the FIFO read side, and its data input is wired to the FIFO data output. It never pops an empty FIFO and holds at most one byte in flight.

## Interface
- CLKS_PER_BIT, 16: clock cycles per serial bit. Legal values are 2 or more. The baud counter width is clog2(CLKS_PER_BIT).
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- fifo_empty  in  1  high when the FIFO holds no data.
- data_in  in  8  FIFO read data, valid the cycle after read_enable is high.
- read_enable  out  1  one-cycle pop strobe to the FIFO.
- tx  out  1  serial line; idles high.
- busy  out  1  high whenever the state is not IDLE.
- tx_done  out  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- All outputs are registered or decoded directly from the state register (Moore). There are no combinational paths from inputs to outputs.
- State machine states: IDLE, POP, LATCH, START, DATA, STOP.
  - IDLE: tx=1. At the clock edge, if fifo_empty=0, move to POP; otherwise stay in IDLE.
  - POP: read_enable=1 for exactly this one cycle, then move to LATCH. fifo_empty is not re-sampled in this state.
  - LATCH: capture data_in into the shift register at the end of this cycle, then move to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then move to DATA with the bit index at 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit. At the end of each bit, shift right and increment the bit index. After bit 7, move to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final cycle of STOP, then move to IDLE.
- Baud counter:
  - Resets to 0 on every state entry.
  - Counts 0..CLKS_PER_BIT-1, and the bit or state advances when the count equals CLKS_PER_BIT-1.
  - The bit index is 3 bits and wraps from 7 only by leaving DATA.
- fifo_empty is ignored outside IDLE. No pop occurs during a frame.
- Reset values: state=IDLE, tx=1, read_enable=0, busy=0, tx_done=0, counters=0, shift register=0.
- Reset mid-frame: the next edge forces all reset values and tx returns high immediately. The byte already popped is dropped, and no extra pop is issued.

## Timing
- Pop latency: fifo_empty is low at edge k. POP (read_enable=1) runs during cycle k+1, LATCH during k+2, and tx falls at the start of k+3.
- Frame length is exactly 10×CLKS_PER_BIT cycles, from tx falling to the end of the stop bit.
- Back-to-back frames: after tx_done, IDLE lasts one cycle, then POP and LATCH. The inter-frame gap of idle-high cycles beyond the stop bit is therefore 3 cycles.
- busy is high from the first POP cycle through the final STOP cycle inclusive. For a single byte that is 10×CLKS_PER_BIT+2 cycles.
- read_enable is never high for two consecutive cycles, and is never high while fifo_empty was 1 at the preceding IDLE sample.

## Test plan
- **Single byte** (CLKS_PER_BIT=4): present data 0x33 and drop fifo_empty once.
  - Exactly one read_enable pulse.
  - tx bit sequence 0,1,1,0,0,1,1,0,0,1, each bit held 4 cycles (40 cycles total).
  - tx_done pulses once; busy is high for 42 cycles.
- **Back-to-back**: FIFO holds 0x33 then 0xCC, with fifo_empty low until the second pop.
  - Two pops spaced 43 cycles apart.
  - Second frame data bits are 0,0,1,1,0,0,1,1, with a 3-cycle idle gap between the frames.
- **Empty FIFO**: fifo_empty held at 1 for 200 cycles.
  - read_enable stays 0, tx stays 1, busy stays 0, tx_done stays 0.
- **Reset mid-frame**: assert reset for 1 cycle during DATA bit 3 of 0xA5.
  - Next cycle: tx=1, busy=0, no pop.
  - If fifo_empty=0 afterwards, a fresh pop follows one IDLE cycle later.
- **Baud boundary** (CLKS_PER_BIT=2): byte 0xFF.
  - Start bit lasts exactly 2 cycles, followed by 18 high cycles (8 data bits plus stop).
  - tx_done is coincident with the 20th frame cycle.
- **Minimum-data corner**: byte 0x00.
  - tx is low for 9×CLKS_PER_BIT contiguous cycles, then the stop bit is high.
